// File: rtl/dma_priority_arbiter.sv
// Four-channel DMA request arbiter: samples channel requests, negotiates the bus
// with the CPU over HRQ/HLDA and grants one channel at a time (fixed or rotating priority).
module dma_priority_arbiter (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [3:0] DREQ,
  input  logic       DREQSense,
  input  logic       DACKSense,
  input  logic [3:0] MaskBits,
  input  logic [3:0] SwReq,
  input  logic       RotatingPriority,
  input  logic       ControllerDisable,
  input  logic       HLDA,
  input  logic       EndService,
  output logic       HRQ,
  output logic [3:0] DACK,
  output logic [3:0] DMA_Req,
  output logic [1:0] ActCH,
  output logic       ldActChn
);

  typedef enum logic [1:0] {IDLE, REQ, GRANT, SERVICE} state_t;

  state_t     state, state_next;
  logic [3:0] dreq_q;
  logic [3:0] pending;
  logic [1:0] ptr, ptr_next;
  logic [1:0] act_next;
  logic       ld_next;
  logic [1:0] winner;
  logic [1:0] base;
  logic [1:0] cand;
  logic       found;
  logic [3:0] dack_act;

  // Normalise request polarity to active-high before masking; software requests bypass the mask.
  assign pending = ((dreq_q ^ {4{DREQSense}}) & ~MaskBits) | SwReq;

  // Scan the registered request vector starting from the priority base.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    base   = RotatingPriority ? ptr : 2'd0;
    winner = base;
    found  = 1'b0;
    cand   = base;
    for (int k = 0; k < 4; k++) begin
      cand = base + 2'(k);
      if (!found && DMA_Req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    act_next   = ActCH;
    ptr_next   = ptr;
    ld_next    = 1'b0;
    case (state)
      IDLE: begin
        if (!ControllerDisable && |DMA_Req) state_next = REQ;
      end
      REQ: begin
        if (DMA_Req == 4'b0000 || ControllerDisable) begin
          state_next = IDLE;
        end else if (HLDA) begin
          // Winner is chosen only now, so late higher-priority requests still win.
          state_next = GRANT;
          act_next   = winner;
          ld_next    = 1'b1;
        end
      end
      GRANT: state_next = SERVICE;
      SERVICE: begin
        if (EndService) begin
          state_next = IDLE;
          if (RotatingPriority) ptr_next = ActCH + 2'd1;
        end else if (!HLDA) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (RESET) begin
      state    <= IDLE;
      HRQ      <= 1'b0;
      ActCH    <= 2'd0;
      ldActChn <= 1'b0;
      DMA_Req  <= 4'b0000;
      dreq_q   <= {4{DREQSense}};
      ptr      <= 2'd0;
    end else begin
      state    <= state_next;
      HRQ      <= (state_next != IDLE);
      ActCH    <= act_next;
      ldActChn <= ld_next;
      DMA_Req  <= pending;
      dreq_q   <= DREQ;
      ptr      <= ptr_next;
    end
  end

  // Acknowledge is forced inactive while reset is held, following the live polarity input.
  assign dack_act = (state == SERVICE && !RESET) ? (4'b0001 << ActCH) : 4'b0000;
  assign DACK     = DACKSense ? dack_act : ~dack_act;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Bench for dma_priority_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_dma_priority_arbiter;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] DREQ = 4'b0000;
  logic       DREQSense = 1'b0;
  logic       DACKSense = 1'b0;
  logic [3:0] MaskBits = 4'b0000;
  logic [3:0] SwReq = 4'b0000;
  logic       RotatingPriority = 1'b0;
  logic       ControllerDisable = 1'b0;
  logic       HLDA = 1'b0;
  logic       EndService = 1'b0;
  logic       HRQ;
  logic [3:0] DACK;
  logic [3:0] DMA_Req;
  logic [1:0] ActCH;
  logic       ldActChn;

  int pass_cnt = 0;
  int total_cnt = 0;

  dma_priority_arbiter dut (
    .CLOCK(CLOCK), .RESET(RESET), .DREQ(DREQ), .DREQSense(DREQSense),
    .DACKSense(DACKSense), .MaskBits(MaskBits), .SwReq(SwReq),
    .RotatingPriority(RotatingPriority), .ControllerDisable(ControllerDisable),
    .HLDA(HLDA), .EndService(EndService), .HRQ(HRQ), .DACK(DACK),
    .DMA_Req(DMA_Req), .ActCH(ActCH), .ldActChn(ldActChn)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  localparam int PH_IDLE = 0, PH_ASK = 1, PH_GRANT = 2, PH_XFER = 3;
  int         m_phase = PH_IDLE;
  logic [3:0] m_sampled = 4'b0000;
  logic [3:0] m_dma_req = 4'b0000;
  logic       m_hrq = 1'b0;
  logic [1:0] m_act = 2'd0;
  logic       m_ld = 1'b0;
  int         m_ptr = 0;
  bit         model_ok = 1'b0;
  logic [3:0] m_seen;

  function automatic logic [1:0] pick(input logic [3:0] p, input int base);
    for (int k = 0; k < 4; k++)
      if (p[(base + k) % 4]) return 2'((base + k) % 4);
    return 2'd0;
  endfunction

  always @(posedge CLOCK) begin
    if (RESET) begin
      m_phase = PH_IDLE; m_hrq = 1'b0; m_act = 2'd0; m_ld = 1'b0;
      m_dma_req = 4'b0000; m_sampled = {4{DREQSense}}; m_ptr = 0;
      model_ok = 1'b1;
    end else begin
      m_seen = m_dma_req;
      m_dma_req = ((m_sampled ^ {4{DREQSense}}) & ~MaskBits) | SwReq;
      m_sampled = DREQ;
      m_ld = 1'b0;
      if (m_phase == PH_IDLE) begin
        if (!ControllerDisable && m_seen != 0) m_phase = PH_ASK;
      end else if (m_phase == PH_ASK) begin
        if (m_seen == 0 || ControllerDisable) m_phase = PH_IDLE;
        else if (HLDA) begin
          m_act = pick(m_seen, RotatingPriority ? m_ptr : 0);
          m_ld = 1'b1;
          m_phase = PH_GRANT;
        end
      end else if (m_phase == PH_GRANT) begin
        m_phase = PH_XFER;
      end else begin
        if (EndService) begin
          m_phase = PH_IDLE;
          if (RotatingPriority) m_ptr = (int'(m_act) + 1) % 4;
        end else if (!HLDA) m_phase = PH_IDLE;
      end
      m_hrq = (m_phase != PH_IDLE);
    end
  end

  logic [3:0] exp_dack;
  always @(negedge CLOCK) begin
    if (model_ok) begin
      exp_dack = (m_phase == PH_XFER && !RESET) ? (4'b0001 << m_act) : 4'b0000;
      if (!DACKSense) exp_dack = ~exp_dack;
      check("cmp_hrq", 4'(HRQ), 4'(m_hrq));
      check("cmp_dack", DACK, exp_dack);
      check("cmp_dma_req", DMA_Req, m_dma_req);
      check("cmp_actch", 4'(ActCH), 4'(m_act));
      check("cmp_ld", 4'(ldActChn), 4'(m_ld));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge CLOCK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; HLDA = 1'b0; EndService = 1'b0; DREQ = 4'b0000;
    MaskBits = 4'b0000; SwReq = 4'b0000; ControllerDisable = 1'b0;
    step();
    RESET = 1'b0;
  endtask

  task automatic wait_hrq(input string name);
    for (int i = 0; i < 12; i++) begin
      step();
      if (HRQ) break;
    end
    check(name, 4'(HRQ), 4'd1);
  endtask

  task automatic wait_ld(input string name);
    for (int i = 0; i < 16; i++) begin
      step();
      if (ldActChn) break;
    end
    check(name, 4'(ldActChn), 4'd1);
  endtask

  initial begin
    step(); step();
    // Fixed priority: 1010 grants ch1, active-low acknowledge.
    DREQSense = 1'b0; DACKSense = 1'b0; RotatingPriority = 1'b0;
    do_reset();
    check("reset_hrq", 4'(HRQ), 4'd0);
    check("reset_dack", DACK, 4'hf);
    DREQ = 4'b1010;
    wait_hrq("fix_hrq_rise");
    repeat (3) step();
    HLDA = 1'b1;
    step();
    check("fix_act", 4'(ActCH), 4'd1);
    check("fix_ld", 4'(ldActChn), 4'd1);
    check("fix_dack_grant", DACK, 4'hf);
    step();
    check("fix_dack_svc", DACK, 4'b1101);
    check("fix_ld_low", 4'(ldActChn), 4'd0);
    EndService = 1'b1; DREQ = 4'b0000;
    step();
    EndService = 1'b0;
    check("fix_hrq_end", 4'(HRQ), 4'd0);
    check("fix_dack_end", DACK, 4'hf);
    step();
    check("fix_b2b_hrq", 4'(HRQ), 4'd1);

    // Rotating: ch2 then 1111 -> ch3, then ch0.
    do_reset();
    RotatingPriority = 1'b1; DREQ = 4'b0100; HLDA = 1'b1;
    wait_ld("rot_ld1");
    check("rot_act2", 4'(ActCH), 4'd2);
    DREQ = 4'b1111;
    step();
    EndService = 1'b1; step(); EndService = 1'b0;
    wait_ld("rot_ld2");
    check("rot_act3", 4'(ActCH), 4'd3);
    step();
    EndService = 1'b1; step(); EndService = 1'b0;
    wait_ld("rot_ld3");
    check("rot_act0", 4'(ActCH), 4'd0);

    // Mask blocks hardware request; software request bypasses the mask.
    do_reset();
    RotatingPriority = 1'b0; MaskBits = 4'b0001; DREQ = 4'b0001;
    repeat (6) step();
    check("mask_hrq", 4'(HRQ), 4'd0);
    check("mask_dma_req", DMA_Req, 4'b0000);
    SwReq = 4'b0001;
    step();
    check("sw_hrq_1", 4'(HRQ), 4'd0);
    step();
    check("sw_hrq_2", 4'(HRQ), 4'd1);

    // Withdrawn request before HLDA.
    do_reset();
    DREQ = 4'b0100;
    wait_hrq("wd_hrq_rise");
    DREQ = 4'b0000;
    step();
    check("wd_dma_1", DMA_Req, 4'b0100);
    step();
    check("wd_dma_0", DMA_Req, 4'b0000);
    check("wd_hrq_hold", 4'(HRQ), 4'd1);
    step();
    check("wd_hrq_drop", 4'(HRQ), 4'd0);

    // HLDA drop in service on ch1 (rotating, active-high DACK), then reset mid-service.
    DACKSense = 1'b1;
    do_reset();
    RotatingPriority = 1'b1; DREQ = 4'b0001; HLDA = 1'b1;
    wait_ld("hd_ld0");
    check("hd_act0", 4'(ActCH), 4'd0);
    DREQ = 4'b0000;
    step();
    EndService = 1'b1; HLDA = 1'b0; step(); EndService = 1'b0;
    step();
    check("hd_idle", 4'(HRQ), 4'd0);
    DREQ = 4'b0010; HLDA = 1'b1;
    wait_ld("hd_ld1");
    check("hd_act1", 4'(ActCH), 4'd1);
    DREQ = 4'b1111;
    step();
    check("hd_dack1", DACK, 4'b0010);
    HLDA = 1'b0;
    step();
    check("hd_dack_off", DACK, 4'b0000);
    check("hd_hrq_off", 4'(HRQ), 4'd0);
    HLDA = 1'b1;
    wait_ld("hd_ld_again");
    check("hd_act1_again", 4'(ActCH), 4'd1);
    step();
    RESET = 1'b1;
    #1;
    check("rst_dack_now", DACK, 4'b0000);
    step();
    check("rst_hrq", 4'(HRQ), 4'd0);
    check("rst_act", 4'(ActCH), 4'd0);
    check("rst_dma", DMA_Req, 4'b0000);
    check("rst_ld", 4'(ldActChn), 4'd0);
    RESET = 1'b0;

    // Active-low request sense.
    DREQSense = 1'b1;
    do_reset();
    DREQ = 4'b1111;
    repeat (4) step();
    check("sense_idle_dma", DMA_Req, 4'b0000);
    DREQ = 4'b0111;
    step(); step();
    check("sense_ch3", DMA_Req, 4'b1000);

    // Randomized traffic, checked by the per-cycle compare process.
    for (int n = 0; n < 4000; n++) begin
      step();
      RESET = ($urandom % 100 == 0);
      if ($urandom % 60 == 0) DREQSense = 1'($urandom);
      if ($urandom % 40 == 0) DACKSense = 1'($urandom);
      if ($urandom % 50 == 0) RotatingPriority = ~RotatingPriority;
      if ($urandom % 3 == 0) DREQ = 4'($urandom);
      if ($urandom % 10 == 0) MaskBits = 4'($urandom) & 4'($urandom);
      if ($urandom % 10 == 0) SwReq = 4'($urandom) & 4'($urandom) & 4'($urandom);
      ControllerDisable = ($urandom % 8 == 0);
      HLDA = HRQ ? ($urandom % 5 != 0) : ($urandom % 10 == 0);
      EndService = ($urandom % 6 == 0);
    end
    step(); step();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dma_priority_arbiter.md
DMA_PRIORITY_ARBITER -- requirements
Module: dma_priority_arbiter

Interface
REQ-001 CLOCK  input  1  single block clock; all state updates on posedge CLOCK.
REQ-002 RESET  input  1  synchronous, active-high reset, sampled on posedge CLOCK.
REQ-003 DREQ  input  4  hardware channel requests, polarity per DREQSense.
REQ-004 DREQSense  input  1  0 = DREQ active high, 1 = DREQ active low.
REQ-005 DACKSense  input  1  0 = DACK active low, 1 = DACK active high.
REQ-006 MaskBits  input  4  1 masks the hardware request of that channel.
REQ-007 SwReq  input  4  software request bits; not affected by MaskBits.
REQ-008 RotatingPriority  input  1  0 = fixed priority (ch0 highest), 1 = rotating.
REQ-009 ControllerDisable  input  1  1 blocks new arbitration; service in progress continues.
REQ-010 HLDA  input  1  hold acknowledge from CPU.
REQ-011 EndService  input  1  one-cycle pulse from timing control: current channel service finished (TC, EOP or single-transfer end).
REQ-012 HRQ  output  1  hold request to CPU, registered.
REQ-013 DACK  output  4  channel acknowledges, polarity per DACKSense.
REQ-014 DMA_Req  output  4  registered pending-request vector to timing control.
REQ-015 ActCH  output  2  granted channel number, registered.
REQ-016 ldActChn  output  1  one-cycle pulse in the cycle ActCH is newly valid.

Function
REQ-017 Sampling: DREQ registered once; Pending = (DREQ_reg XOR {4{DREQSense}}) & ~MaskBits | SwReq; DMA_Req <= Pending each cycle.
REQ-018 FSM states IDLE, REQ, GRANT, SERVICE, one-hot or encoded, registered.
REQ-019 IDLE: if !ControllerDisable and |Pending -> REQ; HRQ = 1 from first REQ cycle; else stay.
REQ-020 REQ: HRQ = 1; if Pending == 0 -> IDLE (HRQ = 0 next cycle); else if HLDA = 1 -> GRANT, latching winner into ActCH on this edge.
REQ-021 Winner: fixed mode = lowest-numbered pending channel; rotating mode = first pending channel scanning Ptr, Ptr+1, ... mod 4.
REQ-022 Arbitration is resolved on the edge HLDA is sampled high, not when HRQ rises; later-arriving higher-priority requests win.
REQ-023 GRANT: exactly one cycle; ldActChn = 1; -> SERVICE.
REQ-024 SERVICE: DACK[ActCH] active, other DACK inactive; HRQ stays 1; ActCH held constant.
REQ-025 SERVICE + EndService -> IDLE; HRQ and DACK inactive next cycle; in rotating mode Ptr <= ActCH + 1 mod 4.
REQ-026 SERVICE + HLDA = 0 without EndService -> IDLE; Ptr unchanged.
REQ-027 EndService and HLDA drop in same cycle: EndService wins (Ptr rotates).
REQ-028 EndService outside SERVICE ignored.
REQ-029 DACK inactive in IDLE, REQ, GRANT; inactive level = ~DACKSense on every bit.
REQ-030 ControllerDisable asserted during REQ: return to IDLE, HRQ drops; during GRANT/SERVICE: no effect.
REQ-031 Back-to-back: after SERVICE->IDLE, a still-pending request re-enters REQ next cycle (HRQ low for exactly one cycle).
REQ-032 Changing RotatingPriority takes effect at the next arbitration; Ptr not cleared.

Reset
REQ-033 RESET = 1: state IDLE, HRQ = 0, ActCH = 0, ldActChn = 0, DMA_Req = 0, DREQ_reg = inactive, Ptr = 0.
REQ-034 During reset DACK = all inactive per current DACKSense.
REQ-035 Reset mid-service aborts immediately; no Ptr update, no ldActChn.

Verification
REQ-036 Fixed: DREQ = 4'b1010, HLDA high 3 cycles after HRQ -> ActCH = 1, ldActChn pulse, DACK[1] active only.
REQ-037 Rotating: service ch2 then DREQ = 4'b1111 -> ActCH = 3; after its EndService next grant ActCH = 0.
REQ-038 Mask: MaskBits = 4'b0001, DREQ = 4'b0001 -> HRQ stays 0; then SwReq = 4'b0001 -> HRQ = 1 two cycles later.
REQ-039 Withdraw: DREQ = 4'b0100 drops before HLDA -> HRQ = 0 the cycle after DMA_Req = 0.
REQ-040 HLDA drop in SERVICE on ch1, rotating -> IDLE, DACK inactive, next arbitration with DREQ = 4'b1111 grants ch1 again.
REQ-041 RESET pulsed in SERVICE -> next cycle HRQ = 0, ActCH = 0, DACK = inactive, DMA_Req = 0.
